bcd_convert_arbiter: RTL and testbench
======================================

# bcd_convert_arbiter

Shared, sequential binary-to-BCD conversion engine for the score/combo display path. Two requesters each present an 8-bit binary value with a req/ack handshake. A round-robin arbiter grants one requester at a time. An iterative shift-and-add-3 (double-dabble) engine converts the value over 8 cycles, and the 3-digit BCD result is latched into that requester's output register.

## Interface
- Parameters: none. Input width is fixed at 8 bits; output is fixed at 3 BCD digits (12 bits).
- clk  input  1  system clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- req0  input  1  requester 0 conversion request; level, held until ack0
- val0  input  8  requester 0 binary value; sampled only at grant
- req1  input  1  requester 1 conversion request; level, held until ack1
- val1  input  8  requester 1 binary value; sampled only at grant
- ack0  output  1  one-cycle pulse: bcd0 updated, request 0 complete
- ack1  output  1  one-cycle pulse: bcd1 updated, request 1 complete
- bcd0  output  12  last result for requester 0, {hundreds, tens, ones}
- bcd1  output  12  last result for requester 1, {hundreds, tens, ones}
- busy  output  1  high whenever the FSM is not in IDLE

## Operation
- FSM states: IDLE, CONVERT, DONE.
- IDLE
  - If neither req is high, stay in IDLE.
  - Otherwise select a grantee, load {12'b0, val_g} into a 20-bit shift register, clear the iteration count, and go to CONVERT.
- Arbitration uses a 1-bit last-served pointer.
  - Single request: grant it.
  - Both requests: grant the requester that was not served last.
  - The pointer resets so that requester 0 wins the first tie.
  - The pointer updates at grant.
- CONVERT: exactly 8 iterations, one per cycle.
  - Each iteration adds 3 to every BCD nibble (bits [19:16], [15:12], [11:8]) that is ≥5, then shifts the whole register left by 1.
  - After the 8th iteration, go to DONE.
- The result is the register's upper 12 bits after iteration 8. Result range is 000–255, so the hundreds nibble is never above 2.
- At the edge completing iteration 8:
  - The grantee's bcd register is written with the result.
  - The grantee's ack register is set.
  - The other requester's bcd is untouched.
- DONE: ack is high for this one cycle. Next edge clears ack and returns to IDLE. Both acks are never high together.
- The request is committed at grant:
  - If the grantee's req drops mid-conversion, the conversion still completes and ack is still pulsed.
  - val changes after grant are ignored.
- A requester must deassert req no later than the edge ending its ack cycle. If req is still high in the following IDLE cycle, it is treated as a new request.
- Reset (asynchronous, any state):
  - state = IDLE, pointer favours requester 0.
  - ack0 = ack1 = 0, bcd0 = bcd1 = 12'h000, busy = 0.
  - Any in-flight conversion is discarded with no ack.

## Timing
- Let E0 be the edge at which IDLE samples req.
- E1–E8 perform the 8 iterations. bcd_g and ack_g are valid immediately after E8.
- At E9 ack drops and the FSM returns to IDLE. The earliest next grant is at E10.
- Throughput: one conversion per 10 cycles. With both requests continuously asserted, acks alternate 0, 1, 0, 1 spaced 10 cycles apart.
- busy
  - rises after E0 and falls after E9;
  - is low in IDLE;
  - is registered.
- All outputs are registered, with no combinational path from the inputs.

## Test plan
- Reset, then req0 = 1 with val0 = 8'd173: ack0 pulses 1 cycle, 8 edges after the grant edge. bcd0 = 12'h173, bcd1 = 12'h000, busy high for 9 cycles.
- Boundary values via req1, sequentially: 0, 9, 10, 99, 100, 255 → bcd1 = 000, 009, 010, 099, 100, 255. No ack0 at any point.
- req0 (val0 = 255) and req1 (val1 = 9) raised in the same cycle after reset: bcd0 = 12'h255 with ack0 first, then bcd1 = 12'h009 with ack1 exactly 10 cycles later.
- Both reqs held for 6 conversions: ack order is 0, 1, 0, 1, 0, 1 and never two consecutive grants to one requester. Then only req1 is held: consecutive ack1 pulses 10 cycles apart.
- After grant with val0 = 42, change val0 to 200 and drop req0 during CONVERT: ack0 still pulses and bcd0 = 12'h042.
- Assert rst_n low at iteration 4 of a conversion: all outputs are 0 immediately. After release there is no ack, and a fresh req0 (val0 = 7) yields bcd0 = 12'h007 with standard latency.

Source files
------------

// File: rtl/bcd_convert_arbiter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// bcd_convert_arbiter
//
// Shared binary-to-BCD converter for the score/combo display path. Two
// requesters hand in 8-bit values over a level req / pulsed ack handshake.
// A round-robin arbiter picks one requester, a double-dabble engine converts
// the value over 8 cycles, and the 3-digit BCD result is stored in that
// requester's output register.
//
// Ports
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   req0   : requester 0 request (level, held until ack0)
//   val0   : requester 0 binary value, sampled at grant
//   req1   : requester 1 request (level, held until ack1)
//   val1   : requester 1 binary value, sampled at grant
//   ack0   : one-cycle pulse, bcd0 has just been updated
//   ack1   : one-cycle pulse, bcd1 has just been updated
//   bcd0   : last result for requester 0, {hundreds, tens, ones}
//   bcd1   : last result for requester 1, {hundreds, tens, ones}
//   busy   : high whenever the engine is not idle
// ---------------------------------------------------------------------------
module bcd_convert_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic [7:0]  val0,
  input  logic        req1,
  input  logic [7:0]  val1,
  output logic        ack0,
  output logic        ack1,
  output logic [11:0] bcd0,
  output logic [11:0] bcd1,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t      state;
  logic        last_served;
  logic        grantee;
  logic [2:0]  iter;
  logic [19:0] shift_reg;
  logic [19:0] adjusted;
  logic [19:0] shift_next;
  logic        grant_sel;

  // On a tie the requester that was not served last wins; a lone request
  // is always granted.
  always_comb begin
    grant_sel = 1'b0;
    if (req0 && req1) begin
      grant_sel = ~last_served;
    end else begin
      grant_sel = req1;
    end
  end

  // One double-dabble iteration: bump every BCD digit that is 5 or more by 3
  // so the following left shift carries correctly into the next digit.
  always_comb begin
    adjusted = shift_reg;
    if (shift_reg[19:16] >= 4'd5) adjusted[19:16] = shift_reg[19:16] + 4'd3;
    if (shift_reg[15:12] >= 4'd5) adjusted[15:12] = shift_reg[15:12] + 4'd3;
    if (shift_reg[11:8]  >= 4'd5) adjusted[11:8]  = shift_reg[11:8]  + 4'd3;
    shift_next = adjusted << 1;
  end

  // Control FSM. last_served resets to 1 so requester 0 wins the first tie.
  // The result is written straight from shift_next on the edge completing
  // the 8th iteration so bcd and ack appear together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_served <= 1'b1;
      grantee     <= 1'b0;
      iter        <= 3'd0;
      shift_reg   <= 20'd0;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      bcd0        <= 12'h000;
      bcd1        <= 12'h000;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            grantee     <= grant_sel;
            last_served <= grant_sel;
            shift_reg   <= {12'b0, (grant_sel ? val1 : val0)};
            iter        <= 3'd0;
            busy        <= 1'b1;
            state       <= CONVERT;
          end
        end
        CONVERT: begin
          shift_reg <= shift_next;
          iter      <= iter + 3'd1;
          if (iter == 3'd7) begin
            if (grantee) begin
              bcd1 <= shift_next[19:8];
              ack1 <= 1'b1;
            end else begin
              bcd0 <= shift_next[19:8];
              ack0 <= 1'b1;
            end
            state <= DONE;
          end
        end
        DONE: begin
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_convert_arbiter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_bcd_convert_arbiter
//
// Self-checking bench for bcd_convert_arbiter. A transaction-level reference
// model (grant decision, edge count since grant, decimal digits by division)
// predicts every output each cycle; directed scenarios add explicit checks
// on values, ack ordering and ack spacing, followed by a randomized phase.
// ---------------------------------------------------------------------------
module tb_bcd_convert_arbiter;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0  = 1'b0;
  logic [7:0]  val0  = 8'd0;
  logic        req1  = 1'b0;
  logic [7:0]  val1  = 8'd0;
  logic        ack0;
  logic        ack1;
  logic [11:0] bcd0;
  logic [11:0] bcd1;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int phase_base = 0;
  int busy_cnt = 0;
  int ack_id_q[$];
  int ack_cyc_q[$];

  // Reference model state
  int          m_n;
  bit          m_busy;
  bit          m_last;
  bit          m_g;
  logic [7:0]  m_val;
  bit          m_ack0;
  bit          m_ack1;
  logic [11:0] m_bcd0;
  logic [11:0] m_bcd1;

  bcd_convert_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req0  (req0),
    .val0  (val0),
    .req1  (req1),
    .val1  (val1),
    .ack0  (ack0),
    .ack1  (ack1),
    .bcd0  (bcd0),
    .bcd1  (bcd1),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  // Decimal digits by plain arithmetic
  function automatic logic [11:0] to_bcd(input int v);
    logic [3:0] h, t, o;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
    return {h, t, o};
  endfunction

  function automatic int ack_id_at(input int i);
    if (i < ack_id_q.size()) return ack_id_q[i];
    return -1;
  endfunction

  function automatic int ack_cyc_at(input int i);
    if (i < ack_cyc_q.size()) return ack_cyc_q[i];
    return -1;
  endfunction

  function automatic int count_id(input int id);
    int n;
    n = 0;
    foreach (ack_id_q[i]) if (ack_id_q[i] == id) n++;
    return n;
  endfunction

  task automatic checkOutput(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: observed %03h required %03h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_n    = -1;
    m_busy = 1'b0;
    m_last = 1'b1;
    m_g    = 1'b0;
    m_val  = 8'd0;
    m_ack0 = 1'b0;
    m_ack1 = 1'b0;
    m_bcd0 = 12'h000;
    m_bcd1 = 12'h000;
  endtask

  // Advance the model by one rising edge: grant when idle, result 8 edges
  // after the grant edge, back to idle one edge later.
  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
    end else if (m_n < 0) begin
      if (req0 || req1) begin
        m_g    = (req0 && req1) ? !m_last : req1;
        m_last = m_g;
        m_val  = m_g ? val1 : val0;
        m_n    = 0;
        m_busy = 1'b1;
      end
    end else begin
      m_n++;
      if (m_n == 8) begin
        if (m_g) begin
          m_bcd1 = to_bcd(int'(m_val));
          m_ack1 = 1'b1;
        end else begin
          m_bcd0 = to_bcd(int'(m_val));
          m_ack0 = 1'b1;
        end
      end else if (m_n == 9) begin
        m_ack0 = 1'b0;
        m_ack1 = 1'b0;
        m_busy = 1'b0;
        m_n    = -1;
      end
    end
  endtask

  task automatic compare_all();
    checkOutput("ack0", {11'b0, ack0}, {11'b0, m_ack0});
    checkOutput("ack1", {11'b0, ack1}, {11'b0, m_ack1});
    checkOutput("busy", {11'b0, busy}, {11'b0, m_busy});
    checkOutput("bcd0", bcd0, m_bcd0);
    checkOutput("bcd1", bcd1, m_bcd1);
  endtask

  // Drive one cycle of inputs, take the edge, sample 1ns later.
  task automatic applyStimulus(input bit r0, input logic [7:0] v0, input bit r1, input logic [7:0] v1);
    req0 = r0;
    val0 = v0;
    req1 = r1;
    val1 = v1;
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    compare_all();
    if (ack0) begin ack_id_q.push_back(0); ack_cyc_q.push_back(cyc - phase_base - 1); end
    if (ack1) begin ack_id_q.push_back(1); ack_cyc_q.push_back(cyc - phase_base - 1); end
    if (busy) busy_cnt++;
  endtask

  task automatic clearLog();
    ack_id_q.delete();
    ack_cyc_q.delete();
    busy_cnt   = 0;
    phase_base = cyc;
  endtask

  // Each enabled requester holds req until its ack (or forever when hold is
  // set, with a fresh random value every cycle).
  task automatic runPhase(input int ncyc, input bit en0, input bit en1, input bit hold,
                          input logic [7:0] v0, input logic [7:0] v1);
    bit done0, done1;
    logic [7:0] a, b;
    done0 = 1'b0;
    done1 = 1'b0;
    clearLog();
    for (int k = 0; k < ncyc; k++) begin
      a = hold ? 8'($urandom) : v0;
      b = hold ? 8'($urandom) : v1;
      applyStimulus(en0 && (hold || !done0), a, en1 && (hold || !done1), b);
      if (ack0) done0 = 1'b1;
      if (ack1) done1 = 1'b1;
    end
  endtask

  task automatic async_reset_pulse();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
  endtask

  int         bvals[6] = '{0, 9, 10, 99, 100, 255};
  logic [11:0] bexp[6] = '{12'h000, 12'h009, 12'h010, 12'h099, 12'h100, 12'h255};

  initial begin
    bit r0, r1;
    model_reset();

    // Reset state
    applyStimulus(0, 8'd0, 0, 8'd0);
    applyStimulus(1, 8'd5, 1, 8'd6);
    checkOutput("rst_busy", {11'b0, busy}, 12'h000);
    checkOutput("rst_bcd0", bcd0, 12'h000);
    checkOutput("rst_ack",  {10'b0, ack1, ack0}, 12'h000);
    rst_n = 1'b1;

    // Single request, value 173
    runPhase(12, 1, 0, 0, 8'd173, 8'd0);
    checkOutput("t1_nacks",   12'(ack_id_q.size()), 12'd1);
    checkOutput("t1_id",      12'(ack_id_at(0)), 12'd0);
    checkOutput("t1_latency", 12'(ack_cyc_at(0)), 12'd8);
    checkOutput("t1_busycnt", 12'(busy_cnt), 12'd9);
    checkOutput("t1_bcd0",    bcd0, 12'h173);
    checkOutput("t1_bcd1",    bcd1, 12'h000);

    // Boundary values through requester 1
    for (int i = 0; i < 6; i++) begin
      runPhase(11, 0, 1, 0, 8'd0, 8'(bvals[i]));
      checkOutput("t2_bcd1",  bcd1, bexp[i]);
      checkOutput("t2_nack0", 12'(count_id(0)), 12'd0);
      checkOutput("t2_nack1", 12'(count_id(1)), 12'd1);
    end

    // Simultaneous requests: 0 first, 1 ten cycles later
    runPhase(22, 1, 1, 0, 8'd255, 8'd9);
    checkOutput("t3_id0",  12'(ack_id_at(0)), 12'd0);
    checkOutput("t3_id1",  12'(ack_id_at(1)), 12'd1);
    checkOutput("t3_gap",  12'(ack_cyc_at(1) - ack_cyc_at(0)), 12'd10);
    checkOutput("t3_bcd0", bcd0, 12'h255);
    checkOutput("t3_bcd1", bcd1, 12'h009);

    // Both held for six conversions, then only requester 1
    runPhase(60, 1, 1, 1, 8'd0, 8'd0);
    checkOutput("t4_nacks", 12'(ack_id_q.size()), 12'd6);
    for (int k = 0; k < 6; k++) begin
      checkOutput("t4_order", 12'(ack_id_at(k)), 12'(k % 2));
      checkOutput("t4_when",  12'(ack_cyc_at(k)), 12'(8 + 10 * k));
    end
    runPhase(40, 0, 1, 1, 8'd0, 8'd0);
    checkOutput("t4b_nacks", 12'(ack_id_q.size()), 12'd4);
    for (int k = 0; k < 4; k++) begin
      checkOutput("t4b_id",   12'(ack_id_at(k)), 12'd1);
      checkOutput("t4b_when", 12'(ack_cyc_at(k)), 12'(8 + 10 * k));
    end

    // Request committed at grant: val change and req drop ignored
    clearLog();
    applyStimulus(1, 8'd42, 0, 8'd0);
    for (int k = 0; k < 11; k++) applyStimulus(0, 8'd200, 0, 8'd0);
    checkOutput("t5_nack0", 12'(count_id(0)), 12'd1);
    checkOutput("t5_bcd0",  bcd0, 12'h042);

    // Reset in the middle of a conversion
    applyStimulus(1, 8'd99, 0, 8'd0);
    for (int k = 0; k < 4; k++) applyStimulus(0, 8'd99, 0, 8'd0);
    async_reset_pulse();
    checkOutput("t6_bcd0", bcd0, 12'h000);
    checkOutput("t6_bcd1", bcd1, 12'h000);
    checkOutput("t6_flags", {9'b0, busy, ack1, ack0}, 12'h000);
    applyStimulus(0, 8'd0, 0, 8'd0);
    applyStimulus(0, 8'd0, 0, 8'd0);
    rst_n = 1'b1;
    clearLog();
    for (int k = 0; k < 12; k++) applyStimulus(0, 8'd0, 0, 8'd0);
    checkOutput("t6_noack", 12'(ack_id_q.size()), 12'd0);
    runPhase(12, 1, 0, 0, 8'd7, 8'd0);
    checkOutput("t6_bcd0_new", bcd0, 12'h007);
    checkOutput("t6_latency",  12'(ack_cyc_at(0)), 12'd8);

    // Randomized traffic with occasional asynchronous resets
    $display("[TB] random phase");
    r0 = 1'b0;
    r1 = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      if (r0) r0 = ($urandom_range(0, 3) != 0);
      else    r0 = ($urandom_range(0, 2) == 0);
      if (r1) r1 = ($urandom_range(0, 3) != 0);
      else    r1 = ($urandom_range(0, 2) == 0);
      applyStimulus(r0, 8'($urandom), r1, 8'($urandom));
      if ($urandom_range(0, 299) == 0) begin
        async_reset_pulse();
        applyStimulus(r0, 8'($urandom), r1, 8'($urandom));
        rst_n = 1'b1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
